// File: rtl/data_memory_param_pkg.sv
// Shared encodings for the byte-addressable data memory: access sizes and FSM states.
// Imported by the interface-facing top and its load-extension helper.
package data_memory_param_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RESP = 2'd2
  } state_e;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/data_memory_param_if.sv
// Request/response bus of the data memory; the requester uses master, the memory uses slave.
interface data_memory_param_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              mem_write;
  logic              mem_read;
  logic [1:0]        mem_size;
  logic              mem_unsigned;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic              rsp_valid;
  logic [DATA_W-1:0] read_data;
  logic              mem_error;

  modport master (
    output req_valid, mem_write, mem_read, mem_size, mem_unsigned, mem_addr, write_data,
    input  req_ready, rsp_valid, read_data, mem_error
  );

  modport slave (
    input  req_valid, mem_write, mem_read, mem_size, mem_unsigned, mem_addr, write_data,
    output req_ready, rsp_valid, read_data, mem_error
  );
endinterface

// File: rtl/dmem_load_extend.sv
// Combinational size select for loads: keeps the low 2^size bytes of the gathered
// little-endian word and sign- or zero-extends them to DATA_W.
module dmem_load_extend
  import data_memory_param_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] raw_data,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] ext_data
);

  logic [DATA_W-1:0] mask;
  logic              sign_bit;

  // Mask-based extension avoids zero-width replications when DATA_W is 32.
  always_comb begin
    mask     = '1;
    sign_bit = raw_data[DATA_W-1];
    case (mem_size_e'(size))
      SZ_BYTE: begin mask = DATA_W'(8'hFF);          sign_bit = raw_data[7];  end
      SZ_HALF: begin mask = DATA_W'(16'hFFFF);       sign_bit = raw_data[15]; end
      SZ_WORD: begin mask = DATA_W'(32'hFFFF_FFFF);  sign_bit = raw_data[31]; end
      default: ;
    endcase
    ext_data = (raw_data & mask) | ((sign_bit && !is_unsigned) ? ~mask : '0);
  end

endmodule

// File: rtl/data_memory_param.sv
// Byte-addressable data memory with self-clearing INIT phase and one-cycle load latency.
// Define DMEM_BOUNDS_CHECK_EN to flag accesses crossing DEPTH instead of wrapping.
module data_memory_param
  import data_memory_param_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                reset,
  data_memory_param_if.slave  bus
);

  localparam int LANES = DATA_W / 8;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]        mem_q [DEPTH];
  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              err_q, err_d;

  logic              accept;
  logic              req_err;
  logic [3:0]        nbytes;
  logic [AW-1:0]     lane_idx [LANES];
  logic [LANES-1:0]  lane_we;
  logic [DATA_W-1:0] raw_load;
  logic [DATA_W-1:0] ext_load;

  assign nbytes = size_bytes(bus.mem_size);
  assign accept = (state_q == IDLE) && bus.req_valid && (bus.mem_read || bus.mem_write);

  always_comb begin
    req_err = (DATA_W == 32) && (bus.mem_size == SZ_DOUBLE);
`ifdef DMEM_BOUNDS_CHECK_EN
    if (({1'b0, bus.mem_addr} + (ADDR_W+1)'(nbytes)) > (ADDR_W+1)'(DEPTH)) begin
      req_err = 1'b1;
    end
`endif
  end

  // Lane k always maps to byte address addr+k, wrapping modulo DEPTH.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_idx[gi]         = bus.mem_addr[AW-1:0] + AW'(gi);
      assign lane_we[gi]          = accept && bus.mem_write && !req_err && (4'(gi) < nbytes);
      assign raw_load[gi*8 +: 8]  = mem_q[lane_idx[gi]];
    end
  endgenerate

  dmem_load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .raw_data    (raw_load),
    .size        (bus.mem_size),
    .is_unsigned (bus.mem_unsigned),
    .ext_data    (ext_load)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    err_d       = err_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          err_d   = req_err;
          if (req_err)             read_data_d = '0;
          else if (!bus.mem_write) read_data_d = ext_load;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      read_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      read_data_q <= read_data_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == INIT) mem_q[cnt_q] <= 8'h00;
      for (int i = 0; i < LANES; i++) begin
        if (lane_we[i]) mem_q[lane_idx[i]] <= bus.write_data[i*8 +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.mem_error = (state_q == RESP) && err_q;
  assign bus.read_data = read_data_q;

endmodule
